// File: rtl/point_link_pkg.sv
// Shared constants, types and byte-selection helper for the point UART link.
package point_link_pkg;

  localparam logic [7:0]  HDR0      = 8'hAA;
  localparam logic [7:0]  HDR1      = 8'h55;
  localparam logic [7:0]  PT_COUNT  = 8'h10;
  localparam int unsigned PKT_LEN   = 69;
  localparam int unsigned CKSUM_IDX = 68;
  localparam int unsigned IDX_W     = 7;
  localparam int unsigned PTS_W     = 256;

  typedef enum logic [1:0] {
    IDLE,
    SNAP,
    LOAD,
    SEND
  } state_e;

  // Frozen copy of the finder outputs for one packet.
  typedef struct packed {
    logic [PTS_W-1:0] h;
    logic [PTS_W-1:0] v;
  } snap_t;

  // Byte at packet index idx: header, sequence, count, big-endian H/V pairs, checksum.
  function automatic logic [7:0] pkt_byte(input logic [IDX_W-1:0] idx,
                                          input logic [7:0]       seq,
                                          input logic [7:0]       cksum,
                                          input snap_t            snap);
    logic [5:0]  p;
    logic [3:0]  k;
    logic [15:0] w;
    p = 6'(idx - 7'd4);
    k = p[5:2];
    w = p[1] ? snap.v[{k, 4'b0000} +: 16] : snap.h[{k, 4'b0000} +: 16];
    if (idx == 7'd0)                   pkt_byte = HDR0;
    else if (idx == 7'd1)              pkt_byte = HDR1;
    else if (idx == 7'd2)              pkt_byte = seq;
    else if (idx == 7'd3)              pkt_byte = PT_COUNT;
    else if (idx == 7'(CKSUM_IDX))     pkt_byte = cksum;
    else                               pkt_byte = p[0] ? w[7:0] : w[15:8];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 27
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] i_DATA,
  input  logic       i_VALID,
  output logic       o_READY,
  output logic       o_DONE,
  output logic       o_TX
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  logic              busy_q;
  logic [BAUD_W-1:0] baud_q;
  logic [3:0]        bit_q;
  logic [8:0]        shift_q;
  logic              tx_q;
  logic              bit_end;

  assign bit_end = busy_q && (baud_q == BAUD_MAX);
  // Done marks the last cycle of the stop bit so the next byte can follow with a 2-cycle gap.
  assign o_DONE  = bit_end && (bit_q == 4'd9);
  assign o_READY = ~busy_q;
  assign o_TX    = tx_q;

  // Bit sequencer: shift register holds remaining data bits plus the stop bit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      tx_q    <= 1'b1;
    end else if (!busy_q) begin
      if (i_VALID) begin
        busy_q  <= 1'b1;
        baud_q  <= '0;
        bit_q   <= '0;
        shift_q <= {1'b1, i_DATA};
        tx_q    <= 1'b0;
      end
    end else if (bit_end) begin
      baud_q <= '0;
      if (bit_q == 4'd9) begin
        busy_q <= 1'b0;
        tx_q   <= 1'b1;
      end else begin
        bit_q   <= bit_q + 4'd1;
        tx_q    <= shift_q[0];
        shift_q <= {1'b1, shift_q[8:1]};
      end
    end else begin
      baud_q <= baud_q + BAUD_W'(1);
    end
  end

endmodule

// File: rtl/point_uart_packetizer.sv
// Per-frame snapshot of 16 centroid pairs, framed into a 69-byte UART packet.
module point_uart_packetizer
  import point_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 27,
  parameter int unsigned NUM_POINTS   = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     VGA_VS,
  input  logic                     i_EN,
  input  logic [16*NUM_POINTS-1:0] i_POINTS_H,
  input  logic [16*NUM_POINTS-1:0] i_POINTS_V,
  output logic                     o_UART_TX,
  output logic                     o_BUSY,
  output logic [7:0]               o_SEQ,
  output logic [7:0]               o_DROP_CNT
);

  state_e           state_q, state_d;
  logic             vs_q;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       drop_q, drop_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       cksum_q, cksum_d;
  logic [7:0]       pkt_seq_q, pkt_seq_d;
  snap_t            snap_q, snap_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             frame_evt;
  logic [7:0]       cur_byte;
  logic             tx_ready;
  logic             tx_done;

  assign frame_evt = vs_q & ~VGA_VS & i_EN;
  assign cur_byte  = pkt_byte(idx_q, pkt_seq_q, cksum_q, snap_q);

  assign o_BUSY     = busy_q;
  assign o_SEQ      = seq_q;
  assign o_DROP_CNT = drop_q;

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      vs_q       <= 1'b0;
      seq_q      <= '0;
      drop_q     <= '0;
      idx_q      <= '0;
      cksum_q    <= '0;
      pkt_seq_q  <= '0;
      snap_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_q       <= VGA_VS;
      seq_q      <= seq_d;
      drop_q     <= drop_d;
      idx_q      <= idx_d;
      cksum_q    <= cksum_d;
      pkt_seq_q  <= pkt_seq_d;
      snap_q     <= snap_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state: frame accounting, snapshot, byte sequencing and checksum.
  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    drop_d     = drop_q;
    idx_d      = idx_q;
    cksum_d    = cksum_q;
    pkt_seq_d  = pkt_seq_q;
    snap_d     = snap_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;

    if (frame_evt) begin
      seq_d = seq_q + 8'd1;
      if (state_q != IDLE && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (frame_evt) state_d = SNAP;
      end
      SNAP: begin
        snap_d    = '{h: i_POINTS_H, v: i_POINTS_V};
        pkt_seq_d = seq_q;
        cksum_d   = '0;
        idx_d     = '0;
        state_d   = LOAD;
      end
      LOAD: begin
        if (tx_ready) begin
          tx_data_d  = cur_byte;
          tx_valid_d = 1'b1;
          if (idx_q >= 7'd2 && idx_q < 7'(CKSUM_IDX)) cksum_d = cksum_q + cur_byte;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_done) begin
          if (idx_q == 7'(CKSUM_IDX)) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 7'd1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_DATA (tx_data_q),
    .i_VALID(tx_valid_q),
    .o_READY(tx_ready),
    .o_DONE (tx_done),
    .o_TX   (o_UART_TX)
  );

endmodule

// File: tb/tb_point_uart_packetizer.sv
// Scoreboard bench: stimulus queues expected bytes, a UART receiver monitor checks them.
module tb_point_uart_packetizer;

  localparam int unsigned CPB     = 4;
  localparam int          PKT_CYC = 69 * 10 * CPB + 68 * 2;

  logic         CLK;
  logic         RST_N;
  logic         VGA_VS;
  logic         i_EN;
  logic [255:0] i_POINTS_H;
  logic [255:0] i_POINTS_V;
  logic         o_UART_TX;
  logic         o_BUSY;
  logic [7:0]   o_SEQ;
  logic [7:0]   o_DROP_CNT;

  point_uart_packetizer #(
    .CLKS_PER_BIT(CPB),
    .NUM_POINTS  (16)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .VGA_VS    (VGA_VS),
    .i_EN      (i_EN),
    .i_POINTS_H(i_POINTS_H),
    .i_POINTS_V(i_POINTS_V),
    .o_UART_TX (o_UART_TX),
    .o_BUSY    (o_BUSY),
    .o_SEQ     (o_SEQ),
    .o_DROP_CNT(o_DROP_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  longint     cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         rx_total = 0;
  int         mon_idx = 0;
  logic [7:0] last_rx = 8'h00;

  logic [255:0] pa_h, pa_v, pb_h, pb_v, pc_h, pc_v;

  function automatic void chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  // Expected packet bytes built independently from the point vectors.
  function automatic void push_packet(input logic [7:0] seq, input logic [255:0] h,
                                      input logic [255:0] v);
    logic [7:0]  b[$];
    logic [7:0]  sum;
    logic [15:0] hw, vw;
    b.push_back(8'hAA);
    b.push_back(8'h55);
    b.push_back(seq);
    b.push_back(8'h10);
    for (int k = 0; k < 16; k++) begin
      hw = h[k*16 +: 16];
      vw = v[k*16 +: 16];
      b.push_back(hw[15:8]);
      b.push_back(hw[7:0]);
      b.push_back(vw[15:8]);
      b.push_back(vw[7:0]);
    end
    sum = 8'h00;
    for (int i = 2; i < 68; i++) sum = sum + b[i];
    b.push_back(sum);
    foreach (b[i]) exp_q.push_back(b[i]);
  endfunction

  // UART receiver: samples mid-bit on negative edges, checks framing, gap and busy.
  initial begin : monitor
    longint     t0, t_prev, t_first;
    logic [7:0] d;
    logic       ok, st, sp, bz;
    t_prev  = 0;
    t_first = 0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        mon_idx = 0;
        continue;
      end
      if (o_UART_TX === 1'b0) begin
        t0 = cyc;
        bz = o_BUSY;
        ok = 1'b1;
        repeat (2) @(negedge CLK);
        ok &= RST_N;
        st = o_UART_TX;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          ok &= RST_N;
          d[i] = o_UART_TX;
        end
        repeat (CPB) @(negedge CLK);
        ok &= RST_N;
        sp = o_UART_TX;
        if (!ok) begin
          mon_idx = 0;
          continue;
        end
        chk("start_bit", int'(st), 0);
        chk("stop_bit", int'(sp), 1);
        chk("busy_during_byte", int'(bz), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none (t=%0t)", d, $time);
        end else begin
          chk($sformatf("byte[%0d]", mon_idx), int'(d), int'(exp_q.pop_front()));
        end
        if (mon_idx == 0) t_first = t0;
        else chk("interbyte_gap", int'(t0 - t_prev), 10 * CPB + 2);
        if (mon_idx == 68) chk("packet_length", int'(t0 - t_first) + 10 * CPB, PKT_CYC);
        t_prev   = t0;
        last_rx  = d;
        rx_total++;
        mon_idx = (mon_idx == 68) ? 0 : mon_idx + 1;
      end
    end
  end

  task automatic vs_edge();
    @(negedge CLK) VGA_VS = 1'b1;
    repeat (2) @(negedge CLK);
    VGA_VS = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic reset_dut();
    @(negedge CLK) RST_N = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < PKT_CYC + 200 && !done; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !o_BUSY) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d bytes pending expected 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_mon_idx(input int n);
    bit done;
    done = 1'b0;
    for (int i = 0; i < PKT_CYC && !done; i++) begin
      @(negedge CLK);
      if (mon_idx == n) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_byte_timeout: got %0d expected %0d", mon_idx, n);
    end
  endtask

  initial begin : stim
    int  rx_before;
    bit  low_seen;
    for (int k = 0; k < 16; k++) begin
      pa_h[k*16 +: 16] = 16'h0100 + 16'(k);
      pa_v[k*16 +: 16] = 16'h0200 + 16'(k);
      pb_h[k*16 +: 16] = 16'h4000 + 16'(k) * 16'h0203;
      pb_v[k*16 +: 16] = 16'hC0F0 - 16'(k) * 16'h0101;
      pc_h[k*16 +: 16] = 16'hFFFF - 16'(k);
      pc_v[k*16 +: 16] = 16'h8000 | (16'(k) << 4);
    end
    RST_N      = 1'b0;
    VGA_VS     = 1'b0;
    i_EN       = 1'b0;
    i_POINTS_H = pa_h;
    i_POINTS_V = pa_v;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Reset values
    chk("reset_tx", int'(o_UART_TX), 1);
    chk("reset_busy", int'(o_BUSY), 0);
    chk("reset_seq", int'(o_SEQ), 0);
    chk("reset_drop", int'(o_DROP_CNT), 0);

    // Disabled frames are ignored
    rx_before = rx_total;
    repeat (3) vs_edge();
    repeat (100) @(negedge CLK);
    chk("en0_traffic", rx_total - rx_before, 0);
    chk("en0_busy", int'(o_BUSY), 0);
    chk("en0_seq", int'(o_SEQ), 0);
    chk("en0_drop", int'(o_DROP_CNT), 0);

    // Known pattern, sequence byte 1
    i_EN = 1'b1;
    push_packet(8'd1, pa_h, pa_v);
    vs_edge();
    chk("known_busy", int'(o_BUSY), 1);
    wait_idle("known");
    chk("known_cksum", int'(last_rx), 8'h31);
    chk("known_seq", int'(o_SEQ), 1);
    chk("known_drop", int'(o_DROP_CNT), 0);

    // Second edge mid-packet is dropped; packet keeps its snapshot
    reset_dut();
    i_POINTS_H = pb_h;
    i_POINTS_V = pb_v;
    push_packet(8'd1, pb_h, pb_v);
    vs_edge();
    wait_mon_idx(10);
    i_POINTS_H = pc_h;
    i_POINTS_V = pc_v;
    vs_edge();
    chk("drop_cnt", int'(o_DROP_CNT), 1);
    chk("drop_seq", int'(o_SEQ), 2);
    wait_idle("drop_pkt");
    push_packet(8'd3, pc_h, pc_v);
    vs_edge();
    wait_idle("after_drop");
    chk("after_drop_seq", int'(o_SEQ), 3);
    chk("after_drop_cnt", int'(o_DROP_CNT), 1);

    // Drop counter saturates
    push_packet(8'd4, pc_h, pc_v);
    vs_edge();
    repeat (260) vs_edge();
    chk("sat_busy", int'(o_BUSY), 1);
    chk("sat_drop", int'(o_DROP_CNT), 255);
    chk("sat_seq", int'(o_SEQ), 8);
    wait_idle("sat");

    // Reset in the middle of a packet
    i_POINTS_H = pa_h;
    i_POINTS_V = pa_v;
    push_packet(8'd9, pa_h, pa_v);
    vs_edge();
    wait_mon_idx(30);
    low_seen = 1'b0;
    for (int i = 0; i < 100 && !low_seen; i++) begin
      @(posedge CLK);
      #1;
      if (o_UART_TX == 1'b0) low_seen = 1'b1;
    end
    chk("midreset_line_low", int'(low_seen), 1);
    #2 RST_N = 1'b0;
    #1;
    chk("midreset_tx", int'(o_UART_TX), 1);
    chk("midreset_busy", int'(o_BUSY), 0);
    chk("midreset_seq", int'(o_SEQ), 0);
    chk("midreset_drop", int'(o_DROP_CNT), 0);
    exp_q.delete();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    push_packet(8'd1, pa_h, pa_v);
    vs_edge();
    wait_idle("post_reset");
    chk("post_reset_seq", int'(o_SEQ), 1);
    chk("post_reset_cksum", int'(last_rx), 8'h31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
